// File: rtl/fib_pkg.sv
// -----------------------------------------------------------------------------
// fib_pkg
// Shared definitions for the fib core: data width, the ALU opcode encoding
// used by both fib_seq and alu, and the fib_seq state encoding.
// -----------------------------------------------------------------------------
package fib_pkg;

    localparam int XLEN = 32;

    typedef enum logic [1:0] {
        ALU_ADD = 2'b00,
        ALU_SUB = 2'b01,
        ALU_SLT = 2'b10
    } aluop_t;

    typedef enum logic [2:0] {
        IDLE,
        CHECK,
        ADD,
        DEC,
        DONE
    } fib_state_t;

endpackage : fib_pkg

// File: rtl/fib_seq_if.sv
// -----------------------------------------------------------------------------
// fib_seq_if
// ALU operand bus between the Fibonacci sequencer (master) and the
// combinational ALU (slave).
//   src0, src1 : operands            (master -> slave)
//   aluop      : operation select    (master -> slave)
//   result     : ALU result          (slave  -> master)
//   zero       : result == 0         (slave  -> master)
// -----------------------------------------------------------------------------
interface fib_seq_if;
    import fib_pkg::*;

    logic [XLEN-1:0] src0;
    logic [XLEN-1:0] src1;
    aluop_t          aluop;
    logic [XLEN-1:0] result;
    logic            zero;

    modport master (
        output src0, src1, aluop,
        input  result, zero
    );

    modport slave (
        input  src0, src1, aluop,
        output result, zero
    );

endinterface : fib_seq_if

// File: rtl/alu.sv
// -----------------------------------------------------------------------------
// alu
// Combinational 32-bit ALU serving the fib sequencer.
//   bus.src0/src1/aluop in : operands and operation (add, sub, signed slt)
//   bus.result/zero     out: result and result==0 flag, same cycle
// -----------------------------------------------------------------------------
module alu
    import fib_pkg::*;
(
    fib_seq_if.slave bus
);

    logic [XLEN-1:0] res;

    // NOTE: every signal assigned in always_comb gets a default first so no
    // path leaves it unassigned and no latch is inferred.
    always_comb begin
        res = '0;
        case (bus.aluop)
            ALU_ADD: res = bus.src0 + bus.src1;
            ALU_SUB: res = bus.src0 - bus.src1;
            ALU_SLT: res = {{(XLEN-1){1'b0}}, ($signed(bus.src0) < $signed(bus.src1))};
            default: res = '0;
        endcase
    end

    assign bus.result = res;
    assign bus.zero   = (res == '0);

endmodule : alu

// File: rtl/fib_seq.sv
// -----------------------------------------------------------------------------
// fib_seq
// Iterative Fibonacci sequencer. Computes fib(n) mod 2^32 by driving an
// external combinational ALU one operation per cycle (CHECK / ADD / DEC loop).
//
// Ports:
//   clk      in   system clock, rising edge
//   rstn     in   asynchronous active-low reset
//   start    in   request, sampled only in IDLE
//   n        in   index, captured on accepted start
//   busy     out  high from the cycle after accept through the DONE cycle
//   done     out  one-cycle pulse, fib_out valid
//   fib_out  out  fib(n) mod 2^32, held until next accept
//   ovf      out  fib(n) >= 2^32 (valid with done)
//   alu_bus  master side of the ALU operand bus
//
// Build option: define FIB_SEQ_OVF_EN to build overflow tracking; otherwise
// ovf is tied to 0. fib_out is the same in both builds.
// -----------------------------------------------------------------------------
module fib_seq
    import fib_pkg::*;
(
    input  logic            clk,
    input  logic            rstn,
    input  logic            start,
    input  logic [XLEN-1:0] n,
    output logic            busy,
    output logic            done,
    output logic [XLEN-1:0] fib_out,
    output logic            ovf,
    fib_seq_if.master       alu_bus
);

    fib_state_t      state;
    logic [XLEN-1:0] a;
    logic [XLEN-1:0] b;
    logic [XLEN-1:0] cnt;

`ifdef FIB_SEQ_OVF_EN
    // Set when the most recent ADD wrapped, i.e. b holds a wrapped value.
    // It is folded into ovf one ADD later, once that value moves into a.
    logic bovf;
`endif

    // ALU operands are registered: each transition loads the operands the
    // next state needs, so they are stable for the whole cycle of that state
    // and the combinational result is consumed at the end of it.
    // NOTE: sequential state uses non-blocking assignments only, so every
    // right-hand side sees the pre-edge value regardless of statement order.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state         <= IDLE;
            a             <= '0;
            b             <= '0;
            cnt           <= '0;
            busy          <= 1'b0;
            done          <= 1'b0;
            fib_out       <= '0;
            alu_bus.src0  <= '0;
            alu_bus.src1  <= '0;
            alu_bus.aluop <= ALU_ADD;
`ifdef FIB_SEQ_OVF_EN
            bovf          <= 1'b0;
            ovf           <= 1'b0;
`endif
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        a             <= '0;
                        b             <= XLEN'(1);
                        cnt           <= n;
                        busy          <= 1'b1;
                        alu_bus.src0  <= n;
                        alu_bus.src1  <= '0;
                        alu_bus.aluop <= ALU_SUB;
                        state         <= CHECK;
`ifdef FIB_SEQ_OVF_EN
                        bovf          <= 1'b0;
                        ovf           <= 1'b0;
`endif
                    end
                end

                CHECK: begin
                    if (alu_bus.zero) begin
                        done          <= 1'b1;
                        fib_out       <= a;
                        alu_bus.src0  <= '0;
                        alu_bus.src1  <= '0;
                        alu_bus.aluop <= ALU_ADD;
                        state         <= DONE;
                    end else begin
                        alu_bus.src0  <= a;
                        alu_bus.src1  <= b;
                        alu_bus.aluop <= ALU_ADD;
                        state         <= ADD;
                    end
                end

                ADD: begin
                    a             <= b;
                    b             <= alu_bus.result;
                    alu_bus.src0  <= cnt;
                    alu_bus.src1  <= XLEN'(1);
                    alu_bus.aluop <= ALU_SUB;
                    state         <= DEC;
`ifdef FIB_SEQ_OVF_EN
                    ovf           <= ovf | bovf;
                    bovf          <= (alu_bus.result < b);
`endif
                end

                DEC: begin
                    cnt           <= alu_bus.result;
                    alu_bus.src0  <= alu_bus.result;
                    alu_bus.src1  <= '0;
                    alu_bus.aluop <= ALU_SUB;
                    state         <= CHECK;
                end

                DONE: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end

                default: begin
                    busy          <= 1'b0;
                    alu_bus.src0  <= '0;
                    alu_bus.src1  <= '0;
                    alu_bus.aluop <= ALU_ADD;
                    state         <= IDLE;
                end
            endcase
        end
    end

`ifndef FIB_SEQ_OVF_EN
    assign ovf = 1'b0;
`endif

endmodule : fib_seq

// File: tb/tb_fib_seq.sv
// -----------------------------------------------------------------------------
// tb_fib_seq
// Self-checking bench for fib_seq paired with alu. Expected values come from
// a plain arithmetic Fibonacci model; cycle numbering counts from the edge
// that accepts start (edge 0), and outputs are sampled on falling edges.
// -----------------------------------------------------------------------------
module tb_fib_seq;
    import fib_pkg::*;

    logic        clk   = 1'b0;
    logic        rstn  = 1'b0;
    logic        start = 1'b0;
    logic [31:0] n     = '0;
    logic        busy;
    logic        done;
    logic [31:0] fib_out;
    logic        ovf;

    int errors = 0;
    int checks = 0;

    fib_seq_if alu_if_i ();

    fib_seq dut (
        .clk     (clk),
        .rstn    (rstn),
        .start   (start),
        .n       (n),
        .busy    (busy),
        .done    (done),
        .fib_out (fib_out),
        .ovf     (ovf),
        .alu_bus (alu_if_i)
    );

    alu u_alu (
        .bus (alu_if_i)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        assert (got === exp)
        else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, got, exp);
        end
    endtask

    // Reference: fib(k) mod 2^32 and whether the true fib(k) reaches 2^32.
    // True values are tracked exactly until they exceed 64 bits' comfort,
    // after which they are known to be large.
    function automatic void fib_ref(input int unsigned k, output logic [31:0] val,
                                    output logic big);
        longint unsigned x, y, t;
        bit sat;
        x   = 0;
        y   = 1;
        sat = 0;
        for (int unsigned i = 0; i < k; i++) begin
            t = x + y;
            x = y;
            y = t;
            if (x >= 64'h0000_0001_0000_0000) sat = 1;
            if (sat) begin
                x = (x % 64'h0000_0001_0000_0000) + 64'h0000_0001_0000_0000;
                y = (y % 64'h0000_0001_0000_0000) + 64'h0000_0001_0000_0000;
            end
        end
        val = x[31:0];
        big = (x >= 64'h0000_0001_0000_0000);
    endfunction

    // Start one run with index nv; optionally re-pulse start during cycles p1
    // and p2 (ignored by the DUT); check timing, busy window, ALU usage, result.
    task automatic run_fib(input logic [31:0] nv, input int p1, input int p2, input string tag);
        logic [31:0] ev;
        logic        eb;
        logic        eo;
        logic [31:0] got_fib;
        logic        got_ovf;
        int          exp_cyc, done_cnt, done_cyc, busy_bad, subs;

        fib_ref(nv, ev, eb);
`ifdef FIB_SEQ_OVF_EN
        eo = eb;
`else
        eo = 1'b0;
`endif
        exp_cyc  = 3 * int'(nv) + 2;
        done_cnt = 0;
        done_cyc = -1;
        busy_bad = 0;
        subs     = 0;
        got_fib  = 'x;
        got_ovf  = 1'bx;

        @(negedge clk);
        n     = nv;
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;

        for (int cyc = 1; cyc <= exp_cyc + 4; cyc++) begin
            @(negedge clk);
            if (busy !== (cyc <= exp_cyc)) busy_bad++;
            if (alu_if_i.aluop === ALU_SUB) subs++;
            if (done === 1'b1) begin
                done_cnt++;
                if (done_cnt == 1) begin
                    done_cyc = cyc;
                    got_fib  = fib_out;
                    got_ovf  = ovf;
                end
            end
            start = (cyc == p1) || (cyc == p2);
        end
        start = 1'b0;

        check({tag, " done_count"}, 64'(done_cnt), 64'd1);
        check({tag, " done_cycle"}, 64'(done_cyc), 64'(exp_cyc));
        check({tag, " fib_out"}, 64'(got_fib), 64'(ev));
        check({tag, " ovf"}, 64'(got_ovf), 64'(eo));
        check({tag, " busy_window_errs"}, 64'(busy_bad), 64'd0);
        check({tag, " alu_sub_count"}, 64'(subs), 64'(2 * nv + 1));
        check({tag, " fib_out_held"}, 64'(fib_out), 64'(ev));
    endtask

    initial begin
        logic [31:0] rn;
        int          stray_done;

        // Reset state
        #1;
        check("rst busy", 64'(busy), 64'd0);
        check("rst done", 64'(done), 64'd0);
        check("rst fib_out", 64'(fib_out), 64'd0);
        check("rst ovf", 64'(ovf), 64'd0);
        check("rst src0", 64'(alu_if_i.src0), 64'd0);
        check("rst src1", 64'(alu_if_i.src1), 64'd0);
        check("rst aluop", 64'(alu_if_i.aluop), 64'd0);
        repeat (2) @(negedge clk);
        rstn = 1'b1;

        // Directed runs
        run_fib(32'd0, -1, -1, "n0");
        run_fib(32'd10, -1, -1, "n10");
        run_fib(32'd47, -1, -1, "n47");
        run_fib(32'd48, -1, -1, "n48");
        run_fib(32'd5, 4, 9, "n5_repulse");
        run_fib(32'd3, -1, -1, "n3");

        // Abort by reset mid-run
        @(negedge clk);
        n     = 32'd20;
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        repeat (10) @(negedge clk);
        #2 rstn = 1'b0;
        #1;
        check("abort busy", 64'(busy), 64'd0);
        check("abort done", 64'(done), 64'd0);
        check("abort fib_out", 64'(fib_out), 64'd0);
        check("abort ovf", 64'(ovf), 64'd0);
        check("abort src0", 64'(alu_if_i.src0), 64'd0);
        check("abort src1", 64'(alu_if_i.src1), 64'd0);
        check("abort aluop", 64'(alu_if_i.aluop), 64'd0);
        stray_done = 0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            if (done !== 1'b0) stray_done++;
        end
        rstn = 1'b1;
        for (int i = 0; i < 70; i++) begin
            @(negedge clk);
            if (done !== 1'b0) stray_done++;
        end
        check("abort no_done", 64'(stray_done), 64'd0);
        run_fib(32'd2, -1, -1, "after_abort_n2");

        // Randomized indices
        for (int i = 0; i < 8; i++) begin
            rn = 32'($urandom_range(0, 60));
            run_fib(rn, -1, -1, $sformatf("rand%0d_n%0d", i, rn));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    // Global watchdog so the run can never hang.
    initial begin
        #200000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

endmodule : tb_fib_seq
